// File: rtl/bits_pkg.sv
// Shared constants and tag type for the bit-extraction request scheduler.
// Tags carry enough context to route and validate each delayed datapath response.
package bits_pkg;

  localparam int WORD_BITS = 32;
  localparam int LEN_W     = 4;
  localparam int MAX_LEN   = 15;
  localparam int DATA_W    = 15;
  localparam int FILL_W    = 11;
  // Sized for the largest supported consumer count (8)
  localparam int TAG_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
    logic [LEN_W-1:0]     len;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, idx: {TAG_IDX_W{1'b0}}, len: {LEN_W{1'b0}}};

endpackage

// File: rtl/bits_req_sched_if.sv
// Bundle of writer, consumer and datapath signals around the request scheduler.
// slave is the scheduler's view; master is the view of everything around it.
interface bits_req_sched_if #(
  parameter int NREQ = 4
);
  import bits_pkg::*;

  logic                    wr_valid;
  logic                    wr_ready;
  logic                    pushin;
  logic [NREQ-1:0]         req_valid;
  logic [LEN_W*NREQ-1:0]   req_len;
  logic [NREQ-1:0]         req_gnt;
  logic                    reqin;
  logic [LEN_W-1:0]        reqlen;
  logic                    pushout;
  logic [LEN_W-1:0]        lenout;
  logic [DATA_W-1:0]       dataout;
  logic [NREQ-1:0]         rsp_valid;
  logic [LEN_W-1:0]        rsp_len;
  logic [DATA_W-1:0]       rsp_data;
  logic [FILL_W-1:0]       fill_bits;
  logic                    proto_err;

  modport master (
    output wr_valid, req_valid, req_len, pushout, lenout, dataout,
    input  wr_ready, pushin, req_gnt, reqin, reqlen, rsp_valid, rsp_len, rsp_data,
    input  fill_bits, proto_err
  );

  modport slave (
    input  wr_valid, req_valid, req_len, pushout, lenout, dataout,
    output wr_ready, pushin, req_gnt, reqin, reqlen, rsp_valid, rsp_len, rsp_data,
    output fill_bits, proto_err
  );

endinterface

// File: rtl/bits_rr_arb.sv
// Round-robin picker: first eligible consumer at or after the pointer wins.
// Produces one-hot grant, its encoded index and the pointer for the next cycle.
module bits_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [IDX_W-1:0] ptr_next
);

  // Wraps base+off into 0..NREQ-1; both operands are already below NREQ.
  function automatic int wrap_idx(input int base, input int off);
    int sum_v;
    sum_v = base + off;
    return (sum_v >= NREQ) ? (sum_v - NREQ) : sum_v;
  endfunction

  // Rotating priority search; each slot is visited once so grant stays one-hot.
  always_comb begin
    int  k_v;
    logic hit_v;
    gnt = {NREQ{1'b0}};
    idx = {IDX_W{1'b0}};
    any = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      k_v    = wrap_idx(int'(ptr), j);
      hit_v  = ~any & elig[k_v];
      gnt[k_v] = hit_v;
      idx    = hit_v ? IDX_W'(k_v) : idx;
      any    = any | hit_v;
    end
  end

  // Pointer advances past the winner, holds when nobody is granted.
  always_comb begin
    ptr_next = ptr;
    if (any) begin
      ptr_next = IDX_W'(wrap_idx(int'(idx), 1));
    end else begin
      ptr_next = ptr;
    end
  end

endmodule

// File: rtl/bits_req_sched.sv
// Flow control, round-robin grant and response steering for the shared bit FIFO.
// Grants only against bits already registered in the fill count.
module bits_req_sched
  import bits_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BUF_BITS = 1024,
  parameter int DP_LAT   = 2
) (
  input logic             clk,
  input logic             rst_n,
  bits_req_sched_if.slave bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [FILL_W-1:0] WR_LIMIT = FILL_W'(BUF_BITS - WORD_BITS);
  localparam logic [FILL_W-1:0] WORD_INC = FILL_W'(WORD_BITS);

  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_next_s;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  ptr_next_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic [NREQ-1:0]   elig_s;
  logic [NREQ-1:0]   gnt_s;
  logic [NREQ-1:0]   rsp_onehot_s;
  logic [NREQ-1:0]   rsp_valid_r;
  logic              gnt_any_s;
  logic              wr_ready_s;
  logic              pushin_s;
  logic              rsp_fire_s;
  logic              perr_set_s;
  logic              perr_r;
  logic [LEN_W-1:0]  reqlen_s;
  logic [LEN_W-1:0]  rsp_len_r;
  logic [DATA_W-1:0] rsp_data_r;
  tag_t              head_s;
  tag_t              tail_s;
  tag_t              pipe_r [DP_LAT];

  assign wr_ready_s = (fill_r <= WR_LIMIT);
  assign pushin_s   = bus.wr_valid & wr_ready_s;

  // Eligibility: a word pushed this cycle is not yet readable.
  always_comb begin
    elig_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = bus.req_valid[i] & (FILL_W'(bus.req_len[i*LEN_W +: LEN_W]) <= fill_r);
    end
  end

  bits_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .elig     (elig_s),
    .ptr      (ptr_r),
    .gnt      (gnt_s),
    .idx      (gnt_idx_s),
    .any      (gnt_any_s),
    .ptr_next (ptr_next_s)
  );

  // Granted length mux, zero when nothing is granted.
  always_comb begin
    reqlen_s = {LEN_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      reqlen_s = reqlen_s | (gnt_s[i] ? bus.req_len[i*LEN_W +: LEN_W] : {LEN_W{1'b0}});
    end
  end

  assign fill_next_s = fill_r + (pushin_s ? WORD_INC : {FILL_W{1'b0}}) - FILL_W'(reqlen_s);

  // Tag entering the in-flight pipe this cycle.
  always_comb begin
    head_s       = TAG_IDLE;
    head_s.valid = gnt_any_s;
    head_s.idx   = TAG_IDX_W'(gnt_idx_s);
    head_s.len   = reqlen_s;
  end

  assign tail_s     = pipe_r[DP_LAT-1];
  assign rsp_fire_s = bus.pushout & tail_s.valid;
  assign perr_set_s = (bus.pushout != tail_s.valid) | (bus.pushout & (bus.lenout != tail_s.len));

  // Decode the tail owner into a per-consumer response strobe.
  always_comb begin
    rsp_onehot_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      rsp_onehot_s[i] = (tail_s.idx == TAG_IDX_W'(i));
    end
  end

  // Fill counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= {FILL_W{1'b0}};
      ptr_r  <= {IDX_W{1'b0}};
    end else begin
      fill_r <= fill_next_s;
      ptr_r  <= ptr_next_s;
    end
  end

  // In-flight tag pipe; the tail lines up with the datapath's pushout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DP_LAT; i++) begin
        pipe_r[i] <= TAG_IDLE;
      end
    end else begin
      pipe_r[0] <= head_s;
      for (int i = 1; i < DP_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Response register and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_len_r   <= {LEN_W{1'b0}};
      rsp_data_r  <= {DATA_W{1'b0}};
      perr_r      <= 1'b0;
    end else begin
      if (rsp_fire_s) begin
        rsp_valid_r <= rsp_onehot_s;
        rsp_len_r   <= bus.lenout;
        rsp_data_r  <= bus.dataout;
      end else begin
        rsp_valid_r <= {NREQ{1'b0}};
      end
      perr_r <= perr_r | perr_set_s;
    end
  end

  assign bus.wr_ready  = wr_ready_s;
  assign bus.pushin    = pushin_s;
  assign bus.req_gnt   = gnt_s;
  assign bus.reqin     = gnt_any_s;
  assign bus.reqlen    = reqlen_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_len   = rsp_len_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.fill_bits = fill_r;
  assign bus.proto_err = perr_r;

endmodule

// File: tb/tb_bits_req_sched.sv
// Randomized and directed bench for bits_req_sched against a queue-based model.
// The bench also plays the datapath, answering each grant DP_LAT cycles later.
module tb_bits_req_sched;
  import bits_pkg::*;

  localparam int N   = 4;
  localparam int BUF = 1024;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bits_req_sched_if #(.NREQ(N)) bus();

  bits_req_sched #(.NREQ(N), .BUF_BITS(BUF), .DP_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int due;
    int idx;
    int len;
  } flight_t;

  flight_t inflight[$];
  int m_fill, m_ptr, cyc;
  int m_rsp_valid, m_rsp_len, m_rsp_data;
  int m_perr;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fill = 0;
    m_ptr  = 0;
    inflight.delete();
    m_rsp_valid = 0;
    m_rsp_len   = 0;
    m_rsp_data  = 0;
    m_perr      = 0;
  endtask

  task automatic clear_inputs();
    bus.wr_valid  = 1'b0;
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.pushout   = 1'b0;
    bus.lenout    = 4'd0;
    bus.dataout   = 15'd0;
  endtask

  // One clock: drive stimulus and datapath, then compare every output with the model.
  task automatic step(input bit wv, input logic [N-1:0] rv, input logic [4*N-1:0] rl, input bit force_po);
    bit due, push, ready;
    int win, k, d;
    int lens[N];
    flight_t f;
    @(posedge clk);
    #1;
    bus.wr_valid  = wv;
    bus.req_valid = rv;
    bus.req_len   = rl;
    d   = 0;
    due = (inflight.size() > 0) && (inflight[0].due == cyc);
    if (due) begin
      d = int'($urandom) & ((1 << inflight[0].len) - 1);
      bus.pushout = 1'b1;
      bus.lenout  = 4'(inflight[0].len);
      bus.dataout = 15'(d);
    end else if (force_po) begin
      bus.pushout = 1'b1;
      bus.lenout  = 4'd3;
      bus.dataout = 15'd5;
    end else begin
      bus.pushout = 1'b0;
      bus.lenout  = 4'd0;
      bus.dataout = 15'd0;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) lens[i] = int'(rl[4*i +: 4]);
    ready = (m_fill <= BUF - 32);
    push  = wv && ready;
    win   = -1;
    for (int j = 0; j < N; j++) begin
      k = (m_ptr + j) % N;
      if (win < 0 && rv[k] && lens[k] <= m_fill) win = k;
    end
    chk("wr_ready", bus.wr_ready, ready);
    chk("pushin", bus.pushin, push);
    chk("req_gnt", bus.req_gnt, (win < 0) ? 0 : (1 << win));
    chk("reqin", bus.reqin, win >= 0);
    if (win >= 0) chk("reqlen", bus.reqlen, lens[win]);
    chk("fill_bits", bus.fill_bits, m_fill);
    chk("rsp_valid", bus.rsp_valid, m_rsp_valid);
    chk("rsp_len", bus.rsp_len, m_rsp_len);
    chk("rsp_data", bus.rsp_data, m_rsp_data);
    chk("proto_err", bus.proto_err, m_perr);
    // advance model to the state after the coming edge
    if (due) begin
      m_rsp_valid = 1 << inflight[0].idx;
      m_rsp_len   = inflight[0].len;
      m_rsp_data  = d;
      void'(inflight.pop_front());
    end else begin
      m_rsp_valid = 0;
      if (force_po) m_perr = 1;
    end
    if (win >= 0) begin
      f.due = cyc + LAT;
      f.idx = win;
      f.len = lens[win];
      inflight.push_back(f);
      m_ptr = (win + 1) % N;
    end
    m_fill = m_fill + (push ? 32 : 0) - ((win >= 0) ? lens[win] : 0);
    cyc++;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_fill"}, bus.fill_bits, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_len"}, bus.rsp_len, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_proto_err"}, bus.proto_err, 0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_zero_outputs(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4*N-1:0] rl_v;
  int pct;

  initial begin
    clear_inputs();
    model_reset();
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // three pushes, no requests
    step(1'b1, 4'b0000, 16'h0000, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step((i < 3), 4'b0000, 16'h0000, 1'b0);
      chk("t1_fill", bus.fill_bits, 32 * i);
      chk("t1_ready", bus.wr_ready, 1);
    end

    // zero-length request from consumer 2 at empty buffer
    do_reset("rst_a");
    step(1'b0, 4'b0100, 16'h0000, 1'b0);
    chk("t5_gnt", bus.req_gnt, 4'b0100);
    repeat (3) step(1'b0, 4'b0000, 16'h0000, 1'b0);
    chk("t5_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("t5_rsp_len", bus.rsp_len, 0);
    chk("t5_rsp_data", bus.rsp_data, 0);
    chk("t5_fill", bus.fill_bits, 0);

    // len 5 request racing a push: not readable until the next cycle
    step(1'b1, 4'b0001, 16'h0005, 1'b0);
    chk("t2_nogrant", bus.req_gnt, 4'b0000);
    step(1'b0, 4'b0001, 16'h0005, 1'b0);
    chk("t2_grant", bus.req_gnt, 4'b0001);
    chk("t2_fill32", bus.fill_bits, 32);
    step(1'b0, 4'b0000, 16'h0000, 1'b0);
    chk("t2_fill27", bus.fill_bits, 27);
    repeat (2) step(1'b0, 4'b0000, 16'h0000, 1'b0);
    chk("t2_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t2_rsp_len", bus.rsp_len, 5);

    // all consumers asking len 4 from fill 128
    do_reset("rst_b");
    repeat (4) step(1'b1, 4'b0000, 16'h0000, 1'b0);
    for (int j = 0; j < 40; j++) begin
      step(1'b0, 4'b1111, 16'h4444, 1'b0);
      if (j < 8) begin
        chk("t3_gnt", bus.req_gnt, 1 << (j % 4));
        chk("t3_fill", bus.fill_bits, 128 - 4 * j);
      end
    end

    // write throttling near full
    do_reset("rst_c");
    repeat (31) step(1'b1, 4'b0000, 16'h0000, 1'b0);
    step(1'b1, 4'b0000, 16'h0000, 1'b0);
    chk("t4_fill992", bus.fill_bits, 992);
    chk("t4_ready992", bus.wr_ready, 1);
    step(1'b1, 4'b0010, 16'h00F0, 1'b0);
    chk("t4_fill1024", bus.fill_bits, 1024);
    chk("t4_ready1024", bus.wr_ready, 0);
    step(1'b1, 4'b0010, 16'h00F0, 1'b0);
    chk("t4_fill1009", bus.fill_bits, 1009);
    chk("t4_ready1009", bus.wr_ready, 0);
    repeat (10) step(1'b1, 4'b0010, 16'h00F0, 1'b0);

    // randomized traffic at several write rates
    for (int seg = 0; seg < 6; seg++) begin
      pct = (seg * 37 + 10) % 100;
      for (int j = 0; j < 500; j++) begin
        rl_v = 16'($urandom);
        if ($urandom_range(0, 3) == 0) rl_v = rl_v & 16'h3333;
        step(($urandom_range(0, 99) < pct), 4'($urandom), rl_v, 1'b0);
      end
    end

    // unexpected pushout with nothing in flight
    repeat (4) step(1'b0, 4'b0000, 16'h0000, 1'b0);
    step(1'b0, 4'b0000, 16'h0000, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 4'b0000, 16'h0000, 1'b0);
      chk("perr_sticky", bus.proto_err, 1);
    end

    // async reset with responses in flight
    repeat (3) step(1'b1, 4'b0000, 16'h0000, 1'b0);
    repeat (3) step(1'b1, 4'b1111, 16'h7359, 1'b0);
    do_reset("rst_mid");
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 4'b0000, 16'h0000, 1'b0);
      chk("post_rst_rsp", bus.rsp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
